// File: rtl/rvv_alu_sequencer.sv
// Vector ALU sequencer: walks an RVV arithmetic op across the vector register,
// issuing one ALU beat per cycle (element chunk by element chunk, S elements per step).
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   start, kill                       launch request (IDLE only), abort of a running op
//   opcode, vsew, vl, nb_lanes        op configuration, latched at start
//   instr_valid                       ALU supports the opcode, sampled with start
//   alu_opcode/alu_vsew/alu_nb_lanes  latched configuration driven to the ALU lanes
//   alu_run                           ALU evaluate enable, high on every RUN beat
//   byte_i, in_reg_offset             base element index and chunk index of the beat
//   lane_en                           per-lane write enable for the beat
//   busy, done, err                   op in flight, completion pulse, error qualifier
module rvv_alu_sequencer #(
    parameter logic [9:0] VLEN       = 10'd128,
    parameter logic [2:0] LANE_WIDTH = 3'b011
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       kill,
    input  logic [5:0] opcode,
    input  logic [2:0] vsew,
    input  logic [9:0] vl,
    input  logic [1:0] nb_lanes,
    input  logic       instr_valid,
    output logic [5:0] alu_opcode,
    output logic [2:0] alu_vsew,
    output logic [1:0] alu_nb_lanes,
    output logic       alu_run,
    output logic [9:0] byte_i,
    output logic [3:0] in_reg_offset,
    output logic [3:0] lane_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state_q, state_n;
    logic [9:0] vl_q, vl_n;
    logic [9:0] byte_n;
    logic [3:0] off_n;
    logic [3:0] lane_n;
    logic [5:0] op_n;
    logic [2:0] sew_n;
    logic [1:0] nb_n;
    logic       run_n, busy_n, done_n, err_n;

    // Start qualification on the live inputs
    logic [3:0] sew_shift;
    logic [9:0] vl_max;
    logic       cfg_ok;

    always_comb begin
        sew_shift = {2'b00, vsew[1:0]} + 4'd3;
        vl_max    = VLEN >> sew_shift;
        cfg_ok    = (vsew <= 3'd3) && instr_valid && (vl <= vl_max);
    end

    // Beat bookkeeping on the latched configuration
    logic [3:0]  log2_c;
    logic [7:0]  c_last;
    logic        chunk_last;
    logic [10:0] step_sz;
    logic [10:0] next_base;
    logic        op_end;

    always_comb begin
        // Elements narrower than a lane take one chunk; wider ones are split into 2^k chunks
        if (({1'b0, alu_vsew} + 4'd3) <= {1'b0, LANE_WIDTH}) begin
            log2_c = 4'd0;
        end else begin
            log2_c = {1'b0, alu_vsew} + 4'd3 - {1'b0, LANE_WIDTH};
        end
        c_last     = (8'd1 << log2_c) - 8'd1;
        chunk_last = ({4'd0, in_reg_offset} == c_last);
        step_sz    = 11'd1 << alu_nb_lanes;
        // 11-bit sum so the end test cannot be fooled by byte_i wrapping
        next_base  = {1'b0, byte_i} + step_sz;
        op_end     = (next_base >= {1'b0, vl_q});
    end

    // Next state and next registered outputs
    always_comb begin
        state_n = state_q;
        byte_n  = byte_i;
        off_n   = in_reg_offset;
        op_n    = alu_opcode;
        sew_n   = alu_vsew;
        nb_n    = alu_nb_lanes;
        vl_n    = vl_q;
        err_n   = 1'b0;
        lane_n  = 4'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    byte_n = 10'd0;
                    off_n  = 4'd0;
                    if (!cfg_ok) begin
                        state_n = FIN;
                        err_n   = 1'b1;
                    end else begin
                        op_n    = opcode;
                        sew_n   = vsew;
                        nb_n    = nb_lanes;
                        vl_n    = vl;
                        state_n = (vl == 10'd0) ? FIN : RUN;
                    end
                end
            end
            RUN: begin
                // Kill wins over the beat advance
                if (kill) begin
                    state_n = IDLE;
                    byte_n  = 10'd0;
                    off_n   = 4'd0;
                end else if (chunk_last) begin
                    off_n = 4'd0;
                    if (op_end) begin
                        state_n = FIN;
                    end else begin
                        byte_n = next_base[9:0];
                    end
                end else begin
                    off_n = in_reg_offset + 4'd1;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        run_n  = (state_n == RUN);
        busy_n = run_n;
        done_n = (state_n == FIN);

        // Lane L writes when its element exists and the lane is part of the step
        for (int l = 0; l < int'(LANES); l++) begin
            lane_n[l] = run_n
                        && (({1'b0, byte_n} + 11'(l)) < {1'b0, vl_n})
                        && (4'(l) < (4'd1 << nb_n));
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            byte_i        <= 10'd0;
            in_reg_offset <= 4'd0;
            alu_opcode    <= 6'd0;
            alu_vsew      <= 3'd0;
            alu_nb_lanes  <= 2'd0;
            vl_q          <= 10'd0;
            alu_run       <= 1'b0;
            lane_en       <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_n;
            byte_i        <= byte_n;
            in_reg_offset <= off_n;
            alu_opcode    <= op_n;
            alu_vsew      <= sew_n;
            alu_nb_lanes  <= nb_n;
            vl_q          <= vl_n;
            alu_run       <= run_n;
            lane_en       <= lane_n;
            busy          <= busy_n;
            done          <= done_n;
            err           <= err_n;
        end
    end

endmodule

// File: tb/tb_rvv_alu_sequencer.sv
// Scoreboard bench for rvv_alu_sequencer: stimulus pushes the expected beats and
// completion pulses (with their cycle stamps), a negedge monitor pops and compares.
module tb_rvv_alu_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic       kill = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [2:0] vsew = 3'd0;
    logic [9:0] vl = 10'd0;
    logic [1:0] nb_lanes = 2'd0;
    logic       instr_valid = 1'b0;
    logic [5:0] alu_opcode;
    logic [2:0] alu_vsew;
    logic [1:0] alu_nb_lanes;
    logic       alu_run;
    logic [9:0] byte_i;
    logic [3:0] in_reg_offset;
    logic [3:0] lane_en;
    logic       busy;
    logic       done;
    logic       err;

    rvv_alu_sequencer dut (
        .clk(clk), .resetn(resetn), .start(start), .kill(kill),
        .opcode(opcode), .vsew(vsew), .vl(vl), .nb_lanes(nb_lanes),
        .instr_valid(instr_valid),
        .alu_opcode(alu_opcode), .alu_vsew(alu_vsew), .alu_nb_lanes(alu_nb_lanes),
        .alu_run(alu_run), .byte_i(byte_i), .in_reg_offset(in_reg_offset),
        .lane_en(lane_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit is_done;
        int cyc;
        int byte_i;
        int off;
        int lane;
        int cfg;
        bit err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_beat(input int c, input int b, input int o, input int ln, input int cfg);
        exp_t t;
        t.is_done = 1'b0; t.cyc = c; t.byte_i = b; t.off = o; t.lane = ln; t.cfg = cfg; t.err = 1'b0;
        sb.push_back(t);
    endtask

    task automatic push_done(input int c, input bit e);
        exp_t t;
        t.is_done = 1'b1; t.cyc = c; t.byte_i = 0; t.off = 0; t.lane = 0; t.cfg = 0; t.err = e;
        sb.push_back(t);
    endtask

    // Reference expansion: elements in steps of S, each element swept chunk by chunk
    task automatic expect_op(input int s, input logic [5:0] op, input logic [2:0] sew,
                             input int vlv, input int nb, input bit iv, input int limit);
        int maxvl[4] = '{16, 8, 4, 2};
        bit bad;
        int nchunk, nstep, k, ln, cfg;
        bad = (sew > 3'd3) || !iv;
        if (!bad && vlv > maxvl[sew[1:0]]) bad = 1'b1;
        if (bad) begin
            push_done(s + 1, 1'b1);
            return;
        end
        nchunk = 1 << sew;
        nstep  = 1 << nb;
        cfg    = {op, sew, nb[1:0]};
        k = 0;
        for (int e = 0; e < vlv; e += nstep) begin
            for (int c = 0; c < nchunk; c++) begin
                ln = 0;
                for (int l = 0; l < nstep && l < 4; l++)
                    if (e + l < vlv) ln |= (1 << l);
                if (k < limit) push_beat(s + 1 + k, e, c, ln, cfg);
                k++;
            end
        end
        if (k <= limit) push_done(s + 1 + k, 1'b0);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [2:0] sew, input logic [9:0] vlv,
                         input logic [1:0] nb, input logic iv);
        opcode = op; vsew = sew; vl = vlv; nb_lanes = nb; instr_valid = iv;
        start = 1'b1;
        step();
        start = 1'b0;
        // Scramble inputs so a latch failure shows up in alu_* or the beat pattern
        opcode = 6'($urandom); vsew = 3'($urandom); vl = 10'($urandom);
        nb_lanes = 2'($urandom); instr_valid = 1'($urandom);
    endtask

    task automatic launch(input logic [5:0] op, input logic [2:0] sew, input int vlv,
                          input int nb, input logic iv, input int limit);
        expect_op(cyc, op, sew, vlv, nb, iv, limit);
        drive(op, sew, 10'(vlv), 2'(nb), iv);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("drain", sb.size(), 0);
        step();
    endtask

    // Monitor
    exp_t m;
    always @(negedge clk) begin
        if (resetn) begin
            if (alu_run || done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {alu_run, done}, 0);
                end else begin
                    m = sb.pop_front();
                    chk("kind_done", done, m.is_done);
                    chk("cycle", cyc, m.cyc);
                    if (m.is_done) begin
                        chk("err", err, m.err);
                        chk("run_in_fin", {alu_run, busy}, 0);
                    end else begin
                        chk("byte_i", byte_i, m.byte_i);
                        chk("in_reg_offset", in_reg_offset, m.off);
                        chk("lane_en", lane_en, m.lane);
                        chk("alu_cfg", {alu_opcode, alu_vsew, alu_nb_lanes}, m.cfg);
                        chk("busy_run", busy, 1);
                    end
                end
            end else begin
                chk("idle_quiet", {lane_en, busy}, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        #1 resetn = 1'b0;
        #1;
        chk("reset_ctl", {alu_run, busy, done, err, lane_en, in_reg_offset}, 0);
        chk("reset_data", {byte_i, alu_opcode, alu_vsew, alu_nb_lanes}, 0);
        step(); step();
        resetn = 1'b1;
        step();

        // vsew=2 on 8-bit lanes: 4 chunks per element, 16 beats, done 17 cycles after start
        launch(6'd0, 3'd2, 4, 0, 1'b1, 1000);
        drain();

        // vsew=0, vl=10, 4 lanes: hand-computed beats
        s = cyc;
        push_beat(s + 1, 0, 0, 4'hF, {6'h15, 3'd0, 2'd2});
        push_beat(s + 2, 4, 0, 4'hF, {6'h15, 3'd0, 2'd2});
        push_beat(s + 3, 8, 0, 4'h3, {6'h15, 3'd0, 2'd2});
        push_done(s + 4, 1'b0);
        drive(6'h15, 3'd0, 10'd10, 2'd2, 1'b1);
        drain();

        // Invalid configurations and the empty op
        launch(6'h01, 3'b100, 1, 0, 1'b1, 1000);
        drain();
        launch(6'h01, 3'd0, 4, 0, 1'b0, 1000);
        drain();
        launch(6'h02, 3'd0, 0, 0, 1'b1, 1000);
        drain();
        launch(6'h02, 3'd0, 17, 0, 1'b1, 1000);
        drain();
        launch(6'h02, 3'd3, 3, 1, 1'b1, 1000);
        drain();

        // Largest legal vl at vsew=0, and 8-chunk elements with 2 lanes
        launch(6'h07, 3'd0, 16, 0, 1'b1, 1000);
        drain();
        launch(6'h2a, 3'd3, 2, 1, 1'b1, 1000);
        drain();

        // start+kill together in IDLE acts as start; start mid-run is ignored
        kill = 1'b1;
        launch(6'h03, 3'd1, 5, 1, 1'b1, 1000);
        kill = 1'b0;
        step(); step();
        opcode = 6'h3f; vsew = 3'd0; vl = 10'd1; nb_lanes = 2'd0; instr_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Kill during beat 5, then restart at once
        launch(6'd0, 3'd2, 4, 0, 1'b1, 6);
        repeat (5) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        launch(6'd0, 3'd2, 4, 0, 1'b1, 1000);
        drain();

        // Reset mid-run: outputs clear without a clock edge, start taken on the first edge after
        launch(6'd0, 3'd2, 4, 0, 1'b1, 3);
        step(); step();
        #2 resetn = 1'b0;
        #1;
        chk("midrun_reset_ctl", {alu_run, busy, done, err, lane_en, in_reg_offset}, 0);
        chk("midrun_reset_data", {byte_i, alu_opcode, alu_vsew, alu_nb_lanes}, 0);
        step();
        resetn = 1'b1;
        launch(6'h15, 3'd0, 10, 2, 1'b1, 1000);
        drain();

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
